// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a one-entry skid buffer.
// Produces the extended immediate, format code, pc+imm target and an illegal flag one cycle after accept.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } dec_t;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] zext5(input logic [4:0] v);
        return XLEN'(v);
    endfunction

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d.imm     = '0;
        d.fmt     = FMT_NONE;
        d.illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            d.illegal = 1'b1;
        end else begin
            case (instr[6:0])
                7'b0000011, 7'b0010011, 7'b1100111: begin
                    d.fmt = FMT_I;
                    d.imm = sext32({{20{instr[31]}}, instr[31:20]});
                end
                7'b0100011: begin
                    d.fmt = FMT_S;
                    d.imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
                end
                7'b1100011: begin
                    d.fmt = FMT_B;
                    d.imm = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                    instr[11:8], 1'b0});
                end
                7'b1101111: begin
                    d.fmt = FMT_J;
                    d.imm = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                    instr[30:21], 1'b0});
                end
                7'b0110111, 7'b0010111: begin
                    d.fmt = FMT_U;
                    d.imm = sext32({instr[31:12], 12'h000});
                end
                7'b1110011: begin
                    // CSR immediate forms; ecall/ebreak/register CSR ops carry no immediate
                    if (instr[13:12] != 2'b00) begin
                        d.fmt = FMT_Z;
                        d.imm = zext5(instr[19:15]);
                    end else begin
                        d.fmt = FMT_NONE;
                    end
                end
                7'b0110011: begin
                    d.fmt = FMT_NONE;
                end
                7'b0011011: begin
                    if (XLEN == 32'd64) begin
                        d.fmt = FMT_I;
                        d.imm = sext32({{20{instr[31]}}, instr[31:20]});
                    end else begin
                        d.illegal = 1'b1;
                    end
                end
                default: begin
                    d.illegal = 1'b1;
                end
            endcase
        end
        return d;
    endfunction

    dec_t   dec_s;
    entry_t new_s;
    entry_t out_r;
    entry_t skid_r;
    logic   out_valid_r;
    logic   skid_valid_r;
    logic   accept_s;
    logic   load_out_s;

    // Decode the incoming word and form the candidate entry
    always_comb begin
        dec_s        = decode(in_instr);
        new_s.imm    = dec_s.imm;
        new_s.fmt    = dec_s.fmt;
        new_s.illegal = dec_s.illegal;
        new_s.pc     = in_pc;
        new_s.target = in_pc + dec_s.imm;
        accept_s     = in_valid && !skid_valid_r && !flush;
        load_out_s   = !out_valid_r || out_ready;
    end

    // Output register and skid register update
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            out_r        <= '0;
            skid_r       <= '0;
        end else if (flush) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (load_out_s) begin
            // a held skid entry is older than anything upstream, so it goes first
            if (skid_valid_r) begin
                out_r        <= skid_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                out_r       <= new_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_r       <= new_s;
            skid_valid_r <= 1'b1;
        end
    end

    assign in_ready    = ~skid_valid_r;
    assign out_valid   = out_valid_r;
    assign out_imm     = out_r.imm;
    assign out_fmt     = out_r.fmt;
    assign out_target  = out_r.target;
    assign out_pc      = out_r.pc;
    assign out_illegal = out_r.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream,
// checked against fixed vectors, hand sequences and a FIFO-level reference model.
module tb_imm_gen_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] pc64;

    logic        rdy32, ov32, ill32;
    logic [2:0]  fmt32;
    logic [31:0] imm32, tgt32, pco32;
    logic        rdy64, ov64, ill64;
    logic [2:0]  fmt64;
    logic [63:0] imm64, tgt64, pco64;

    int n_cmp  = 0;
    int n_fail = 0;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(pc64[31:0]),
        .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_target(tgt32), .out_pc(pco32), .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(pc64),
        .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_target(tgt64), .out_pc(pco64), .out_illegal(ill64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference decode from the ISA field definitions, done with integer arithmetic
    function automatic void ref_decode(input logic [31:0] instr, input int xlen,
                                       output logic [63:0] imm, output logic [2:0] fmt,
                                       output logic ill);
        longint v = 0;
        fmt = 3'd0;
        ill = 1'b0;
        if (instr[1:0] != 2'b11) ill = 1'b1;
        else begin
            case (instr[6:0])
                7'h03, 7'h13, 7'h67: begin
                    fmt = 3'd1; v = longint'(instr[31:20]); if (v >= 2048) v -= 4096;
                end
                7'h1B: begin
                    if (xlen == 64) begin
                        fmt = 3'd1; v = longint'(instr[31:20]); if (v >= 2048) v -= 4096;
                    end else ill = 1'b1;
                end
                7'h23: begin
                    fmt = 3'd2;
                    v = longint'(instr[31:25]) * 32 + longint'(instr[11:7]);
                    if (v >= 2048) v -= 4096;
                end
                7'h63: begin
                    fmt = 3'd3;
                    v = longint'(instr[31]) * 4096 + longint'(instr[7]) * 2048
                      + longint'(instr[30:25]) * 32 + longint'(instr[11:8]) * 2;
                    if (v >= 4096) v -= 8192;
                end
                7'h6F: begin
                    fmt = 3'd5;
                    v = longint'(instr[31]) * (1 << 20) + longint'(instr[19:12]) * 4096
                      + longint'(instr[20]) * 2048 + longint'(instr[30:21]) * 2;
                    if (v >= (1 << 20)) v -= (1 << 21);
                end
                7'h37, 7'h17: begin
                    fmt = 3'd4;
                    v = longint'(instr[31:12]) * 4096;
                    if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
                end
                7'h73: begin
                    if (instr[13:12] != 2'b00) begin
                        fmt = 3'd6; v = longint'(instr[19:15]);
                    end
                end
                7'h33: fmt = 3'd0;
                default: ill = 1'b1;
            endcase
        end
        imm = v;
        if (xlen == 32) imm = imm & 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Compare the output entry of both instances against the model for (instr, pc)
    task automatic check_out(input string tag, input logic [31:0] instr, input logic [63:0] pc);
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        ref_decode(instr, 32, e_imm, e_fmt, e_ill);
        check({tag, ".imm32"}, 64'(imm32), e_imm);
        check({tag, ".fmt32"}, 64'(fmt32), 64'(e_fmt));
        check({tag, ".ill32"}, 64'(ill32), 64'(e_ill));
        check({tag, ".pc32"}, 64'(pco32), pc & 64'hFFFF_FFFF);
        check({tag, ".tgt32"}, 64'(tgt32), (pc + e_imm) & 64'hFFFF_FFFF);
        ref_decode(instr, 64, e_imm, e_fmt, e_ill);
        check({tag, ".imm64"}, imm64, e_imm);
        check({tag, ".fmt64"}, 64'(fmt64), 64'(e_fmt));
        check({tag, ".ill64"}, 64'(ill64), 64'(e_ill));
        check({tag, ".pc64"}, pco64, pc);
        check({tag, ".tgt64"}, tgt64, pc + e_imm);
    endtask

    task automatic check_hs(input string tag, input logic ov, input logic rdy);
        check({tag, ".ov32"}, 64'(ov32), 64'(ov));
        check({tag, ".ov64"}, 64'(ov64), 64'(ov));
        check({tag, ".rdy32"}, 64'(rdy32), 64'(rdy));
        check({tag, ".rdy64"}, 64'(rdy64), 64'(rdy));
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;

    vec_t vecs[15];

    logic [31:0] q_instr[$];
    logic [63:0] q_pc[$];
    logic [6:0]  opcs[12];

    initial begin
        logic [31:0] e32;
        logic [31:0] r;
        bit          rdy_m;
        int          sel;

        vecs = '{
            '{32'hFFF00093, 64'h100, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0},
            '{32'hFE000EE3, 64'h100, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0},
            '{32'h123452B7, 64'h0,   32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0},
            '{32'h800002B7, 64'h0,   32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0},
            '{32'hFFF0009B, 64'h10,  32'h00000000, 3'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0},
            '{32'h00000000, 64'h4,   32'h00000000, 3'd0, 1'b1, 64'h0,                3'd0, 1'b1},
            '{32'h0002D073, 64'h0,   32'h00000005, 3'd6, 1'b0, 64'h5,                3'd6, 1'b0},
            '{32'h00000073, 64'h0,   32'h00000000, 3'd0, 1'b0, 64'h0,                3'd0, 1'b0},
            '{32'hFE112E23, 64'h200, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0},
            '{32'h0080006F, 64'hFFFFFFFC, 32'h00000008, 3'd5, 1'b0, 64'h8,           3'd5, 1'b0},
            '{32'h00000033, 64'h8,   32'h00000000, 3'd0, 1'b0, 64'h0,                3'd0, 1'b0},
            '{32'h00000001, 64'h8,   32'h00000000, 3'd0, 1'b1, 64'h0,                3'd0, 1'b1},
            '{32'h0000007F, 64'h8,   32'h00000000, 3'd0, 1'b1, 64'h0,                3'd0, 1'b1},
            '{32'hFFF00093, 64'hFFFFFFFFFFFFFFF0, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0},
            '{32'h00C08067, 64'h40,  32'h0000000C, 3'd1, 1'b0, 64'hC,                3'd1, 1'b0}
        };
        opcs = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h33, 7'h1B, 7'h7F};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; pc64 = 64'h0;
        tick();
        tick();
        check_hs("reset", 1'b0, 1'b1);
        check("reset.imm64", imm64, 64'h0);
        check("reset.tgt64", tgt64, 64'h0);
        check("reset.pc32", 64'(pco32), 64'h0);
        check("reset.fmt32", 64'(fmt32), 64'h0);
        check("reset.ill64", 64'(ill64), 64'h0);
        reset = 1'b0;

        // Fixed vectors streamed back to back at full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            pc64     = vecs[i].pc;
            tick();
            check_hs($sformatf("vec%0d", i), 1'b1, 1'b1);
            check($sformatf("vec%0d.imm32", i), 64'(imm32), 64'(vecs[i].imm32));
            check($sformatf("vec%0d.fmt32", i), 64'(fmt32), 64'(vecs[i].fmt32));
            check($sformatf("vec%0d.ill32", i), 64'(ill32), 64'(vecs[i].ill32));
            e32 = vecs[i].pc[31:0] + vecs[i].imm32;
            check($sformatf("vec%0d.tgt32", i), 64'(tgt32), 64'(e32));
            check($sformatf("vec%0d.imm64", i), imm64, vecs[i].imm64);
            check($sformatf("vec%0d.fmt64", i), 64'(fmt64), 64'(vecs[i].fmt64));
            check($sformatf("vec%0d.ill64", i), 64'(ill64), 64'(vecs[i].ill64));
            check($sformatf("vec%0d.tgt64", i), tgt64, vecs[i].pc + vecs[i].imm64);
        end
        in_valid = 1'b0;
        tick();
        check_hs("drain", 1'b0, 1'b1);

        // Back-pressure: three offered, two held, then released in order
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'hFFF00093; pc64 = 64'h1000;
        tick(); check_hs("bp1", 1'b1, 1'b1); check_out("bp1", 32'hFFF00093, 64'h1000);
        in_instr = 32'hFE000EE3; pc64 = 64'h1004;
        tick(); check_hs("bp2", 1'b1, 1'b0); check_out("bp2", 32'hFFF00093, 64'h1000);
        in_instr = 32'h123452B7; pc64 = 64'h1008;
        tick(); check_hs("bp3", 1'b1, 1'b0); check_out("bp3", 32'hFFF00093, 64'h1000);
        out_ready = 1'b1;
        tick(); check_hs("bp4", 1'b1, 1'b1); check_out("bp4", 32'hFE000EE3, 64'h1004);
        tick(); check_hs("bp5", 1'b1, 1'b1); check_out("bp5", 32'h123452B7, 64'h1008);
        in_valid = 1'b0;
        tick(); check_hs("bp6", 1'b0, 1'b1);

        // Flush with both registers full and another word offered
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h0002D073; pc64 = 64'h2000; tick();
        pc64 = 64'h2004; tick();
        check_hs("fl_full", 1'b1, 1'b0);
        pc64 = 64'h2008; flush = 1'b1;
        tick(); check_hs("fl1", 1'b0, 1'b1);
        pc64 = 64'h200C;
        tick(); check_hs("fl2", 1'b0, 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); check_hs("fl3", 1'b0, 1'b1);

        // Reset while both registers hold entries
        out_ready = 1'b0; in_valid = 1'b1;
        pc64 = 64'h3000; tick();
        pc64 = 64'h3004; tick();
        reset = 1'b1;
        tick(); check_hs("rst_mid", 1'b0, 1'b1);
        check("rst_mid.pc64", pco64, 64'h0);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); check_hs("rst_after", 1'b0, 1'b1);

        // Randomised traffic against a two-deep FIFO model
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            r   = $urandom;
            sel = $urandom_range(0, 13);
            in_instr = (sel < 12) ? {r[31:7], opcs[sel]} : r;
            pc64 = {32'($urandom), 32'($urandom)};
            rdy_m = (q_instr.size() < 2);
            if (flush) begin
                q_instr.delete();
                q_pc.delete();
            end else begin
                if (q_instr.size() > 0 && out_ready) begin
                    void'(q_instr.pop_front());
                    void'(q_pc.pop_front());
                end
                if (in_valid && rdy_m) begin
                    q_instr.push_back(in_instr);
                    q_pc.push_back(pc64);
                end
            end
            tick();
            check_hs("rnd", q_instr.size() > 0, q_instr.size() < 2);
            if (q_instr.size() > 0) check_out("rnd", q_instr[0], q_pc[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parameter-width immediate generator for the decode stage of the pipelined RISC-V core. It accepts one 32-bit instruction plus its PC per cycle over a valid/ready handshake. One cycle later it presents the sign/zero-extended immediate, a format code, the PC-relative target `pc + imm`, and an illegal-encoding flag. A one-entry skid buffer gives full throughput under back-pressure, and a synchronous flush supports branch redirect.

## Interface
- `XLEN`, 32, datapath width; legal values 32 or 64; immediates sign-extend to XLEN.
- `clk`  in  1  sole clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all valid state.
- `flush`  in  1  synchronous; discards any held entry and the entry being accepted this cycle.
- `in_valid`  in  1  upstream holds instruction.
- `in_ready`  out  1  block can accept; equals NOT skid_valid.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  XLEN  instruction address.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_imm`  out  XLEN  extended immediate.
- `out_fmt`  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
- `out_target`  out  XLEN  `out_pc + out_imm`, modulo 2^XLEN.
- `out_pc`  out  XLEN  PC of output entry.
- `out_illegal`  out  1  opcode not recognised for this XLEN, or `instr[1:0] != 2'b11`.

## Operation
- Decode uses opcode `instr[6:0]`.
  - 0000011, 0010011, 1100111 → I: `sext(instr[31:20])`.
  - 0100011 → S: `sext({instr[31:25], instr[11:7]})`.
  - 1100011 → B: `sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})`; bit 0 is always 0.
  - 1101111 → J: `sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})`.
  - 0110111, 0010111 → U: `sext({instr[31:12], 12'b0})`; sign-extends above bit 31 when XLEN=64.
  - 1110011 with `funct3[1:0] != 0` → Z: `zext(instr[19:15])`.
  - 1110011 with `funct3[1:0] == 0` → NONE, imm 0, not illegal.
  - 0110011 → NONE, imm 0, not illegal.
  - 0011011 → I when XLEN=64; treated as unknown when XLEN=32.
  - Unknown opcode → NONE, imm 0, illegal=1.
  - `instr[1:0] != 2'b11` → illegal=1, fmt NONE, imm 0, regardless of opcode.
- Target: computed for every format; XLEN-bit add, carry discarded. Downstream ignores it for NONE/Z.
- Storage: output register (`out_*`) plus one skid register holding identical fields.
- Accept condition: `in_valid && in_ready && !flush`.
  - If the output register is empty or being drained (`out_ready`), the accepted entry loads the output register.
  - Otherwise it loads the skid register.
- When the output register drains with the skid full, skid contents move to the output register and the skid clears.
- Order is strictly FIFO; no entry is dropped or duplicated.
- Flush: next cycle `out_valid=0` and the skid is empty; any same-cycle accept is ignored.
- Reset has priority over flush. Flush has priority over accept.

## Timing
- Reset values: `out_valid=0`, skid_valid=0, hence `in_ready=1`. `out_imm`, `out_target`, `out_pc` = 0, `out_fmt=0`, `out_illegal=0`.
- Latency: accept in cycle N → `out_valid=1` with results in cycle N+1.
- Throughput: one entry per cycle while `out_ready=1`.
- Output stability: `out_*` is stable while `out_valid && !out_ready`.
- Back-pressure: first stalled accept fills the skid, and `in_ready` drops in the following cycle. With both registers full, at most 2 entries are in flight.
- After `out_ready` rises, the skid entry appears on the output one cycle later, and `in_ready` returns to 1 in that same cycle.
- Reset mid-stream: all held entries are lost; no `out_valid` pulse in the cycle after reset.
- `in_ready` is a function of state only; there is no combinational path from `out_ready` to `in_ready`.

## Test plan
- **Basic I-type:** XLEN=32, `0xFFF00093` (addi x1,x0,-1) with pc `0x100` → next cycle `out_imm=0xFFFFFFFF`, fmt 1, `target=0x000000FF`, illegal 0.
- **B and U formats:** `0xFE000EE3` (beq x0,x0,-4), pc `0x100` → `imm=0xFFFFFFFC`, fmt 3, `target=0xFC`. Then `0x123452B7` (lui) → `imm=0x12345000`, fmt 4.
- **Back-pressure:** hold `out_ready=0` and stream 3 valid instructions → 2 accepted, `in_ready=0` from the cycle after the second accept. Raise `out_ready` → all 3 emerge in order, no gaps once flowing.
- **Flush:** both registers full plus `in_valid=1`, assert `flush` one cycle → next cycle `out_valid=0`, `in_ready=1`, and the flushed entries never appear.
- **XLEN=64:** `0xFFF0009B` (addiw) → `imm=0xFFFFFFFFFFFFFFFF`, fmt 1, not illegal. Same word with XLEN=32 → illegal 1, fmt 0. `0x800002B7` (lui) → `imm=0xFFFFFFFF80000000`.
- **Illegal/CSR/reset:** `0x00000000` → illegal 1. `0x0002D073` (csrrwi x0,0,5) → fmt 6, `imm=5`. Assert `reset` with entries held → next cycle `out_valid=0`, `in_ready=1`.
